// File: rtl/xpb_pkg.sv
// Shared types and helpers for the run-time loadable xpb reduction table.
package xpb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_READY = 2'd2;

  // Number of table entries addressed by a digit of the given width.
  function automatic int unsigned lut_depth(input int unsigned digit_bits);
    return 32'(1) << digit_bits;
  endfunction

  // LSB position of channel ch inside a bus packed with width-bit fields.
  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/xpb_lut_load_fsm.sv
// Load sequencer: walks entries 1..depth-1 and reports table readiness.
module xpb_lut_load_fsm
  import xpb_pkg::*;
#(
  parameter int unsigned DIGIT_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  load_done,
  output logic                  table_ready,
  output logic                  wr_en_c,
  output logic [DIGIT_BITS-1:0] wr_idx_c
);

  localparam logic [DIGIT_BITS-1:0] CNT_FIRST = DIGIT_BITS'(1);
  localparam logic [DIGIT_BITS-1:0] CNT_LAST  = '1;

  state_t                state;
  state_t                state_nxt;
  logic [DIGIT_BITS-1:0] cnt;
  logic [DIGIT_BITS-1:0] cnt_nxt;
  logic                  done_nxt;

  // Next-state, counter and write-strobe decode; a restart always beats a pending beat.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    wr_en_c   = 1'b0;
    wr_idx_c  = cnt;
    case (state)
      ST_IDLE: begin
        if (load_start) begin
          state_nxt = ST_LOAD;
          cnt_nxt   = CNT_FIRST;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          cnt_nxt = CNT_FIRST;
        end else if (load_valid) begin
          wr_en_c = 1'b1;
          if (cnt == CNT_LAST) begin
            state_nxt = ST_READY;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + DIGIT_BITS'(1);
          end
        end
      end
      ST_READY: begin
        if (load_start) begin
          state_nxt = ST_LOAD;
          cnt_nxt   = CNT_FIRST;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = CNT_FIRST;
      end
    endcase
  end

  // State, counter and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= CNT_FIRST;
      load_ready  <= 1'b0;
      load_done   <= 1'b0;
      table_ready <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      load_ready  <= (state_nxt == ST_LOAD);
      load_done   <= done_nxt;
      table_ready <= (state_nxt == ST_READY);
    end
  end

endmodule

// File: rtl/xpb_lut_bank.sv
// Loadable xpb multiple table with NUM_CH pipelined digit lookups.
module xpb_lut_bank
  import xpb_pkg::*;
#(
  parameter int unsigned DIGIT_BITS = 5,
  parameter int unsigned WORD_BITS  = 1024,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_start,
  input  logic                          load_valid,
  input  logic [WORD_BITS-1:0]          load_data,
  output logic                          load_ready,
  output logic                          load_done,
  output logic                          table_ready,
  input  logic                          lk_valid,
  input  logic [NUM_CH*DIGIT_BITS-1:0]  lk_idx,
  output logic                          out_valid,
  output logic [NUM_CH*WORD_BITS-1:0]   out_data,
  output logic                          out_err
);

  localparam int unsigned DEPTH = lut_depth(DIGIT_BITS);

  logic                          wr_en_c;
  logic [DIGIT_BITS-1:0]         wr_idx_c;
  logic [WORD_BITS-1:0]          mem [1:DEPTH-1];
  logic                          req_valid;
  logic                          req_err;
  logic [NUM_CH*DIGIT_BITS-1:0]  req_idx;
  logic [NUM_CH*WORD_BITS-1:0]   rd_data;

  xpb_lut_load_fsm #(
    .DIGIT_BITS (DIGIT_BITS)
  ) u_load_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .table_ready (table_ready),
    .wr_en_c     (wr_en_c),
    .wr_idx_c    (wr_idx_c)
  );

  // Table storage; entry 0 is a constant zero and has no storage.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_idx_c] <= load_data;
    end
  end

  // Optional request register; the error flag is taken in the request's sample cycle.
  if (LATENCY == 2) begin : g_lat2
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        req_valid <= 1'b0;
        req_err   <= 1'b0;
        req_idx   <= '0;
      end else begin
        req_valid <= lk_valid;
        if (lk_valid) begin
          req_err <= ~table_ready;
          req_idx <= lk_idx;
        end
      end
    end
  end else begin : g_lat1
    assign req_valid = lk_valid;
    assign req_err   = ~table_ready;
    assign req_idx   = lk_idx;
  end

  // Per-channel read; error requests and index 0 return zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!req_err && (req_idx[ch_lsb(c, DIGIT_BITS) +: DIGIT_BITS] != '0)) begin
        rd_data[ch_lsb(c, WORD_BITS) +: WORD_BITS] = mem[req_idx[ch_lsb(c, DIGIT_BITS) +: DIGIT_BITS]];
      end
    end
  end

  // Output register; data and error hold between valid strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= req_valid;
      if (req_valid) begin
        out_err  <= req_err;
        out_data <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_xpb_lut_bank.sv
// Randomized bench for xpb_lut_bank, running LATENCY=1 and LATENCY=2 side by side.
module tb_xpb_lut_bank;

  localparam int unsigned DIGIT_BITS = 5;
  localparam int unsigned WORD_BITS  = 1024;
  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned DEPTH      = 32;
  localparam int unsigned DW         = NUM_CH * WORD_BITS;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_READY = 2;

  logic                          clk;
  logic                          rst_n;
  logic                          load_start;
  logic                          load_valid;
  logic [WORD_BITS-1:0]          load_data;
  logic                          lk_valid;
  logic [NUM_CH*DIGIT_BITS-1:0]  lk_idx;

  logic          o1_load_ready, o1_load_done, o1_table_ready, o1_out_valid, o1_out_err;
  logic [DW-1:0] o1_out_data;
  logic          o2_load_ready, o2_load_done, o2_table_ready, o2_out_valid, o2_out_err;
  logic [DW-1:0] o2_out_data;

  xpb_lut_bank #(
    .DIGIT_BITS(DIGIT_BITS), .WORD_BITS(WORD_BITS), .NUM_CH(NUM_CH), .LATENCY(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(o1_load_ready), .load_done(o1_load_done),
    .table_ready(o1_table_ready), .lk_valid(lk_valid), .lk_idx(lk_idx),
    .out_valid(o1_out_valid), .out_data(o1_out_data), .out_err(o1_out_err)
  );

  xpb_lut_bank #(
    .DIGIT_BITS(DIGIT_BITS), .WORD_BITS(WORD_BITS), .NUM_CH(NUM_CH), .LATENCY(2)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(o2_load_ready), .load_done(o2_load_done),
    .table_ready(o2_table_ready), .lk_valid(lk_valid), .lk_idx(lk_idx),
    .out_valid(o2_out_valid), .out_data(o2_out_data), .out_err(o2_out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: table contents, load progress and expected responses per latency.
  logic [WORD_BITS-1:0] tbl [DEPTH];
  int                   m_mode;
  int                   m_k;
  logic                 m_done;
  logic                 p_v, p_e;
  logic [DW-1:0]        p_d;
  logic                 x1_v, x1_e, x2_v, x2_e;
  logic [DW-1:0]        x1_d, x2_d;

  int n_tests;
  int n_fail;
  int nd1, nd2;

  function automatic logic [31:0] fold(input logic [DW-1:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < int'(DW / 32); i++) r ^= v[i*32 +: 32];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h (fold %h) expected %h (fold %h) at %0t",
               tag, got[63:0], fold(got), exp[63:0], fold(exp), $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_k    = 1;
    m_done = 1'b0;
    p_v = 1'b0; p_e = 1'b0; p_d = '0;
    x1_v = 1'b0; x1_e = 1'b0; x1_d = '0;
    x2_v = 1'b0; x2_e = 1'b0; x2_d = '0;
  endtask

  task automatic chk_dut(input string pfx, input logic lr, input logic ld, input logic tr,
                         input logic ov, input logic oe, input logic [DW-1:0] od,
                         input logic xv, input logic xe, input logic [DW-1:0] xd);
    chk({pfx, "load_ready"},  DW'(lr), DW'(m_mode == M_LOAD));
    chk({pfx, "load_done"},   DW'(ld), DW'(m_done));
    chk({pfx, "table_ready"}, DW'(tr), DW'(m_mode == M_READY));
    chk({pfx, "out_valid"},   DW'(ov), DW'(xv));
    chk({pfx, "out_err"},     DW'(oe), DW'(xe));
    chk({pfx, "out_data"},    od, xd);
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare.
  task automatic step();
    logic          rv, re;
    logic [DW-1:0] rd;
    @(posedge clk);
    rv = lk_valid;
    re = (m_mode != M_READY);
    rd = '0;
    if (!re) begin
      for (int c = 0; c < int'(NUM_CH); c++) rd[c*WORD_BITS +: WORD_BITS] = tbl[lk_idx[c*DIGIT_BITS +: DIGIT_BITS]];
    end
    x2_v = p_v;
    if (p_v) begin x2_e = p_e; x2_d = p_d; end
    p_v = rv; p_e = re; p_d = rd;
    x1_v = rv;
    if (rv) begin x1_e = re; x1_d = rd; end
    m_done = 1'b0;
    if (m_mode == M_IDLE) begin
      if (load_start) begin m_mode = M_LOAD; m_k = 1; end
    end else if (m_mode == M_LOAD) begin
      if (load_start) begin
        m_k = 1;
      end else if (load_valid) begin
        tbl[m_k] = load_data;
        if (m_k == int'(DEPTH) - 1) begin m_mode = M_READY; m_done = 1'b1; end
        else m_k++;
      end
    end else begin
      if (load_start) begin m_mode = M_LOAD; m_k = 1; end
    end
    #1;
    chk_dut("l1_", o1_load_ready, o1_load_done, o1_table_ready, o1_out_valid, o1_out_err, o1_out_data, x1_v, x1_e, x1_d);
    chk_dut("l2_", o2_load_ready, o2_load_done, o2_table_ready, o2_out_valid, o2_out_err, o2_out_data, x2_v, x2_e, x2_d);
    if (o1_load_done) nd1++;
    if (o2_load_done) nd2++;
  endtask

  task automatic rand_lk();
    lk_valid = 1'($urandom_range(0, 1));
    lk_idx   = (NUM_CH*DIGIT_BITS)'($urandom);
  endtask

  task automatic set_lk(input int a, input int b);
    lk_valid = 1'b1;
    lk_idx   = {5'(b), 5'(a)};
  endtask

  function automatic logic [WORD_BITS-1:0] pat(input int k);
    logic [WORD_BITS-1:0] v;
    for (int i = 0; i < int'(WORD_BITS / 32); i++) v[i*32 +: 32] = 32'(k) * 32'h0101_0101;
    return v;
  endfunction

  function automatic logic [WORD_BITS-1:0] rnd_word();
    logic [WORD_BITS-1:0] v;
    for (int i = 0; i < int'(WORD_BITS / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Feed n accepted beats with random valid gaps; kind 0 = counting pattern, else random data.
  task automatic load_beats(input int n, input int kind);
    for (int k = 1; k <= n; k++) begin
      while ($urandom_range(0, 2) == 0) begin
        load_valid = 1'b0;
        load_data  = rnd_word();
        rand_lk();
        step();
      end
      load_valid = 1'b1;
      load_data  = (kind == 0) ? pat(k) : rnd_word();
      rand_lk();
      step();
    end
    load_valid = 1'b0;
  endtask

  task automatic idle_inputs();
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    lk_valid   = 1'b0;
    lk_idx     = '0;
  endtask

  // Assert reset mid-cycle, check cleared outputs, then release on a falling edge.
  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1;
    idle_inputs();
    model_reset();
    chk_dut("rst1_", o1_load_ready, o1_load_done, o1_table_ready, o1_out_valid, o1_out_err, o1_out_data, 1'b0, 1'b0, '0);
    chk_dut("rst2_", o2_load_ready, o2_load_done, o2_table_ready, o2_out_valid, o2_out_err, o2_out_data, 1'b0, 1'b0, '0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    nd1 = 0;
    nd2 = 0;
    for (int i = 0; i < int'(DEPTH); i++) tbl[i] = '0;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    reset_mid();

    // Lookup before any load errors with zero data.
    set_lk(3, 0);
    step();
    lk_valid = 1'b0;
    step();
    step();

    // Pattern load with gaps; exactly one load_done pulse.
    nd1 = 0; nd2 = 0;
    load_start = 1'b1; rand_lk(); step();
    load_start = 1'b0;
    load_beats(31, 0);
    lk_valid = 1'b0;
    step();
    step();
    chk("t2_done_cnt_l1", DW'(nd1), DW'(1));
    chk("t2_done_cnt_l2", DW'(nd2), DW'(1));

    // Back-to-back lookups in READY, then a random burst.
    set_lk(1, 31); step();
    set_lk(0, 17); step();
    set_lk(5, 5);  step();
    lk_valid = 1'b0;
    step(); step(); step();
    for (int i = 0; i < 40; i++) begin rand_lk(); step(); end

    // Restart at cnt=20 with a discarded beat, then full random reload.
    load_start = 1'b1; lk_valid = 1'b0; step();
    load_start = 1'b0;
    load_beats(19, 1);
    load_start = 1'b1; load_valid = 1'b1; load_data = {(WORD_BITS/8){8'hA5}}; step();
    load_start = 1'b0; load_valid = 1'b0;
    nd1 = 0; nd2 = 0;
    load_beats(31, 1);
    lk_valid = 1'b0;
    step();
    chk("t4_done_cnt_l1", DW'(nd1), DW'(1));
    for (int i = 0; i < int'(DEPTH); i += 2) begin set_lk(i, i + 1); step(); end
    for (int i = 0; i < 30; i++) begin rand_lk(); step(); end

    // Restart coinciding with the final beat: no done, table stays not ready.
    nd1 = 0; nd2 = 0;
    load_start = 1'b1; lk_valid = 1'b0; step();
    load_start = 1'b0;
    load_beats(30, 1);
    load_start = 1'b1; load_valid = 1'b1; load_data = rnd_word(); step();
    load_start = 1'b0; load_valid = 1'b0;
    set_lk(7, 9); step();
    lk_valid = 1'b0;
    step(); step();
    chk("t5_done_cnt_l1", DW'(nd1), DW'(0));
    chk("t5_done_cnt_l2", DW'(nd2), DW'(0));
    chk("t5_table_ready", DW'(o1_table_ready), DW'(0));

    // Complete a reload, put two lookups in flight and drop reset.
    load_beats(31, 1);
    step();
    set_lk(2, 30); step();
    set_lk(31, 4); step();
    reset_mid();
    for (int i = 0; i < 10; i++) begin rand_lk(); step(); end
    load_start = 1'b1; lk_valid = 1'b0; step();
    load_start = 1'b0;
    load_beats(31, 1);
    for (int i = 0; i < 30; i++) begin rand_lk(); step(); end
    lk_valid = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
